// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: sample-count constants and the
// helper that turns (prescale, samp_num) into a sampling window.
package uart_rx_pkg;

  localparam int SAMP_LIMIT = 7;
  localparam int SAMP_CNT_W = $clog2(SAMP_LIMIT + 1);

  // Internal width used by the window helper; PRESCALE_W must not exceed it.
  localparam int WIN_W = 16;

  localparam logic [2:0] SAMP_1 = 3'd1;
  localparam logic [2:0] SAMP_3 = 3'd3;
  localparam logic [2:0] SAMP_5 = 3'd5;
  localparam logic [2:0] SAMP_7 = 3'd7;

  localparam logic [WIN_W-1:0] P_MIN = WIN_W'(2);

  typedef struct packed {
    logic [WIN_W-1:0]      lo;
    logic [WIN_W-1:0]      hi;
    logic [SAMP_CNT_W-1:0] n_eff;
    logic                  cfg_err;
  } win_t;

  // Window centred on the mid-bit edge. Any illegal request collapses to a
  // single sample at mid so the receiver keeps working in a degraded mode.
  function automatic win_t calc_window(input logic [WIN_W-1:0] p,
                                       input logic [2:0]       sn,
                                       input logic [2:0]       max_s);
    win_t             w;
    logic [WIN_W-1:0] mid;
    logic [WIN_W-1:0] h;
    logic             legal;
    mid   = (p < P_MIN) ? '0 : (p >> 1) - WIN_W'(1);
    h     = WIN_W'((sn - 3'd1) >> 1);
    legal = ((sn == SAMP_1) || (sn == SAMP_3) || (sn == SAMP_5) || (sn == SAMP_7)) &&
            (sn <= max_s) && (p >= P_MIN) && (mid >= h);
    w.cfg_err = ~legal;
    w.n_eff   = legal ? SAMP_CNT_W'(sn) : SAMP_CNT_W'(1);
    w.lo      = legal ? (mid - h) : mid;
    w.hi      = legal ? (mid + h) : mid;
    return w;
  endfunction

endpackage

// File: rtl/sample_window.sv
// Combinational window decode for the majority-vote sampler.
module sample_window
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = 5
) (
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [2:0]            samp_num,
  output logic [PRESCALE_W-1:0] win_lo,
  output logic [PRESCALE_W-1:0] win_hi,
  output logic [SAMP_CNT_W-1:0] n_eff,
  output logic                  cfg_err
);

  win_t w;
  logic unused_win;

  // Decode the window bounds and legality from the frame configuration
  always_comb begin
    w = calc_window(WIN_W'(prescale), samp_num, 3'(MAX_SAMPLES));
  end

  // Bounds never exceed prescale, so the upper bits are always zero.
  assign win_lo     = PRESCALE_W'(w.lo);
  assign win_hi     = PRESCALE_W'(w.hi);
  assign n_eff      = w.n_eff;
  assign cfg_err    = w.cfg_err;
  assign unused_win = ^{w.lo, w.hi};

endmodule

// File: rtl/data_sampling_mv.sv
// Majority-vote sampler: counts ones across a window of oversampling edges
// around mid-bit and emits the voted bit with a one-cycle valid strobe.
module data_sampling_mv
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  data_samp_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [2:0]            samp_num,
  input  logic                  RX_IN,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);

  logic                  en_q;
  logic                  en_first;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [2:0]            samp_num_q;
  logic [PRESCALE_W-1:0] p_eff;
  logic [2:0]            sn_eff;

  logic [PRESCALE_W-1:0] win_lo;
  logic [PRESCALE_W-1:0] win_hi;
  logic [SAMP_CNT_W-1:0] n_eff;
  logic                  win_cfg_err;

  logic [SAMP_CNT_W-1:0] ones_q;
  logic [SAMP_CNT_W-1:0] taken_q;
  logic                  armed_q;

  logic                  at_zero;
  logic                  in_win;
  logic                  armed_eff;
  logic                  vote;
  logic [SAMP_CNT_W-1:0] ones_tot;
  logic [SAMP_CNT_W-1:0] taken_tot;
  logic [SAMP_CNT_W-1:0] h_eff;

  // The first enabled cycle uses the live inputs so its window is already valid.
  assign en_first = data_samp_en & ~en_q;
  assign p_eff    = en_first ? prescale : prescale_q;
  assign sn_eff   = en_first ? samp_num : samp_num_q;

  sample_window #(
    .PRESCALE_W  (PRESCALE_W),
    .MAX_SAMPLES (MAX_SAMPLES)
  ) u_sample_window (
    .prescale (p_eff),
    .samp_num (sn_eff),
    .win_lo   (win_lo),
    .win_hi   (win_hi),
    .n_eff    (n_eff),
    .cfg_err  (win_cfg_err)
  );

  // Running totals including this cycle's sample, and the vote decision.
  // A bit is only voted once its start (edge 0) has been seen in this frame,
  // so a frame entered mid-bit never produces a partial-window vote.
  always_comb begin
    at_zero   = (edge_cnt == '0);
    in_win    = (edge_cnt >= win_lo) && (edge_cnt <= win_hi);
    ones_tot  = (at_zero ? '0 : ones_q)  + SAMP_CNT_W'(in_win & RX_IN);
    taken_tot = (at_zero ? '0 : taken_q) + SAMP_CNT_W'(in_win);
    armed_eff = armed_q | at_zero;
    vote      = data_samp_en & armed_eff & (edge_cnt == win_hi);
    h_eff     = (n_eff - SAMP_CNT_W'(1)) >> 1;
  end

  // Track enable history and hold the frame configuration until enable drops
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      samp_num_q <= '0;
    end else begin
      en_q <= data_samp_en;
      if (!data_samp_en) begin
        prescale_q <= '0;
        samp_num_q <= '0;
      end else if (en_first) begin
        prescale_q <= prescale;
        samp_num_q <= samp_num;
      end
    end
  end

  // Accumulate window samples; cleared while idle, at bit start and after a vote
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ones_q  <= '0;
      taken_q <= '0;
      armed_q <= 1'b0;
    end else if (!data_samp_en) begin
      ones_q  <= '0;
      taken_q <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_eff;
      if (vote) begin
        ones_q  <= '0;
        taken_q <= '0;
      end else begin
        ones_q  <= ones_tot;
        taken_q <= taken_tot;
      end
    end
  end

  // Register the voted bit, strobe and status flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      noise_err    <= 1'b0;
      cfg_err      <= 1'b0;
    end else if (!data_samp_en) begin
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      noise_err    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      sample_valid <= vote;
      cfg_err      <= win_cfg_err;
      if (vote) begin
        sampled_bit <= (ones_tot > h_eff);
        noise_err   <= ((ones_tot != '0) && (ones_tot != n_eff)) || (taken_tot != n_eff);
      end
    end
  end

endmodule

// File: tb/tb_data_sampling_mv.sv
// Scoreboard bench for data_sampling_mv: expected votes are queued as the
// window's last edge is driven and matched against each sample_valid pulse.
module tb_data_sampling_mv;

  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          data_samp_en = 1'b0;
  logic [PW-1:0] edge_cnt = '0;
  logic [PW-1:0] prescale = '0;
  logic [2:0]    samp_num = '0;
  logic          RX_IN = 1'b1;
  logic          sampled_bit;
  logic          sample_valid;
  logic          noise_err;
  logic          cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int bit_v;
    int noise;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  data_sampling_mv #(
    .PRESCALE_W  (PW),
    .MAX_SAMPLES (5)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .prescale     (prescale),
    .samp_num     (samp_num),
    .RX_IN        (RX_IN),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .noise_err    (noise_err),
    .cfg_err      (cfg_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Match every valid pulse against the oldest expected vote
  always @(negedge CLK) begin
    if (sample_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", sample_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("valid_cyc", cyc, mon_e.cyc);
        chk("vote_bit", sampled_bit, mon_e.bit_v);
        chk("vote_noise", noise_err, mon_e.noise);
      end
    end
  end

  task automatic drive(input logic en, input int ec, input logic rx);
    data_samp_en = en;
    edge_cnt     = PW'(ec);
    RX_IN        = rx;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b1);
  endtask

  // One full bit period; rx[e] is the line value at edge e, lo..hi the window.
  task automatic send_bit(input int p, input int lo, input int hi,
                          input logic [15:0] rx, input bit vote, input int ecfg);
    int   ones;
    int   n;
    exp_t e;
    ones = 0;
    n    = hi - lo + 1;
    e    = '{cyc: 0, bit_v: 1, noise: 0};
    for (int i = lo; i <= hi; i++) ones += int'(rx[i]);
    for (int ei = 0; ei < p; ei++) begin
      if (vote && ei == hi) begin
        e.cyc   = cyc + 1;
        e.bit_v = (ones > (n - 1) / 2) ? 1 : 0;
        e.noise = (ones != 0 && ones != n) ? 1 : 0;
        sb_q.push_back(e);
      end
      drive(1'b1, ei, rx[ei]);
    end
    chk("cfg_err", cfg_err, ecfg);
    if (vote) chk("hold_bit", sampled_bit, e.bit_v);
  endtask

  initial begin
    #12;
    chk("rst_bit", sampled_bit, 1);
    chk("rst_valid", sample_valid, 0);
    chk("rst_noise", noise_err, 0);
    chk("rst_cfg", cfg_err, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(2);

    // P=8, N=3: clean zero, clean one, noisy one; pulses P cycles apart
    prescale = 6'd8;
    samp_num = 3'd3;
    send_bit(8, 2, 4, 16'hFFE3, 1'b1, 0);
    send_bit(8, 2, 4, 16'hFFFF, 1'b1, 0);
    send_bit(8, 2, 4, 16'hFFF7, 1'b1, 0);
    idle(1);
    chk("idle_bit", sampled_bit, 1);
    idle(1);

    // P=16, N=5: 1,1,0,1,0 at edges 5..9
    prescale = 6'd16;
    samp_num = 3'd5;
    send_bit(16, 5, 9, 16'hFD7F, 1'b1, 0);
    idle(2);

    // P=4, N=5: mid < h, falls back to a single sample at edge 1
    prescale = 6'd4;
    samp_num = 3'd5;
    send_bit(4, 1, 1, 16'hFFFD, 1'b1, 1);
    send_bit(4, 1, 1, 16'hFFFF, 1'b1, 1);
    idle(2);
    chk("cfg_clr_idle", cfg_err, 0);

    // samp_num=4 illegal; mid-frame change to 3 is ignored until en toggles
    prescale = 6'd8;
    samp_num = 3'd4;
    send_bit(8, 3, 3, 16'hFFF7, 1'b1, 1);
    samp_num = 3'd3;
    send_bit(8, 3, 3, 16'hFFEB, 1'b1, 1);
    idle(2);
    send_bit(8, 2, 4, 16'hFFEB, 1'b1, 0);
    idle(2);

    // samp_num=7 above MAX_SAMPLES=5
    prescale = 6'd16;
    samp_num = 3'd7;
    send_bit(16, 7, 7, 16'hFF7F, 1'b1, 1);
    idle(2);

    // Enable dropped at edge 3 of window 2..4
    prescale = 6'd8;
    samp_num = 3'd3;
    send_bit(8, 2, 4, 16'hFFE3, 1'b1, 0);
    drive(1'b1, 0, 1'b1);
    drive(1'b1, 1, 1'b1);
    drive(1'b1, 2, 1'b0);
    drive(1'b0, 3, 1'b0);
    chk("drop_bit", sampled_bit, 1);
    chk("drop_noise", noise_err, 0);
    chk("drop_valid", sample_valid, 0);
    for (int i = 4; i < 8; i++) drive(1'b0, i, 1'b0);
    send_bit(8, 2, 4, 16'hFFE3, 1'b1, 0);
    send_bit(8, 2, 4, 16'hFFF7, 1'b1, 0);
    idle(2);

    // Reset asserted at edge 3 mid-window
    send_bit(8, 2, 4, 16'hFFEB, 1'b1, 0);
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 1, 1'b0);
    drive(1'b1, 2, 1'b0);
    edge_cnt = PW'(3);
    RST      = 1'b0;
    #1;
    chk("arst_bit", sampled_bit, 1);
    chk("arst_valid", sample_valid, 0);
    chk("arst_noise", noise_err, 0);
    chk("arst_cfg", cfg_err, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int i = 3; i < 8; i++) drive(1'b1, i, 1'b0);
    chk("post_rst_hold", sampled_bit, 1);
    send_bit(8, 2, 4, 16'h0000, 1'b1, 0);
    send_bit(8, 2, 4, 16'hFFFF, 1'b1, 0);
    idle(3);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
